// File: rtl/pll_reconfig_seq.sv
// SDRAM PLL reconfiguration sequencer: ordered Avalon-MM writes, PLL reset pulse, lock wait, C1 phase step.
// Optional PLLSEQ_RETRY_EN: repeat the full sequence once after the first lock timeout of a request.
//
// state | meaning
// IDLE  | waiting for a valid req
// WR    | issuing list A (frequency registers)
// RST   | pll_reset held high for RST_CYCLES
// LOCKW | waiting for locked, bounded by LOCK_TIMEOUT
// PH_WR | issuing list B (C1 phase step)
// FIN   | one-cycle done, commit cur_pos/cur_phase if no error
module pll_reconfig_seq #(
   parameter int NUM_CFG      = 11,
   parameter int PH_BASE      = 29,
   parameter int RST_CYCLES   = 8,
   parameter int LOCK_TIMEOUT = 50000
) (
   input  logic        CLK_50M,
   input  logic        RESET,
   input  logic        req,
   input  logic [3:0]  req_pos,
   input  logic [7:0]  req_phase,
   input  logic        phase_only,
   output logic [3:0]  cfg_idx,
   input  logic [31:0] cfg_m,
   input  logic [31:0] cfg_k,
   input  logic [31:0] cfg_c,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        mgmt_write,
   input  logic        mgmt_waitrequest,
   input  logic        locked,
   output logic        pll_reset,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [3:0]  cur_pos,
   output logic [7:0]  cur_phase
);

   localparam int         TMR_MAX  = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
   localparam int         TW       = $clog2(TMR_MAX + 1);
   localparam logic [7:0] PH_BASE8 = 8'(PH_BASE);
   localparam logic [4:0] NUM_CFG5 = 5'(NUM_CFG);

   typedef enum logic [2:0] {IDLE, WR, RST, LOCKW, PH_WR, FIN} state_t;

   state_t          state, state_nxt;
   logic [3:0]      pos_q;
   logic [7:0]      phase_q;
   logic [31:0]     ph_word;
   logic [TW-1:0]   tmr;
   logic [3:0]      wr_idx;
   logic            wr_gap;
   logic            wr_fire;
   logic            accept;
   logic            retry_avail;

   function automatic logic [31:0] ph_word_f(input logic [7:0] base, input logic [7:0] tgt);
      logic [8:0] b9, t9, d9;
      b9 = {1'b0, base};
      t9 = {1'b0, tgt};
      if (t9 > b9) begin
         d9 = t9 - b9;
         ph_word_f = {23'd0, d9} | 32'h0001_0000;
      end else begin
         d9 = b9 - t9;
         ph_word_f = {23'd0, d9} | 32'h0021_0000;
      end
   endfunction

   assign accept  = (state == IDLE) && req && ({1'b0, req_pos} < NUM_CFG5);
   assign wr_fire = !wr_gap && !mgmt_waitrequest;

   always_ff @(posedge CLK_50M) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)
                     state_nxt = !phase_only ? WR : ((req_phase == cur_phase) ? FIN : PH_WR);
         WR:      if (wr_fire && wr_idx == 4'd8) state_nxt = RST;
         RST:     if (tmr == '0) state_nxt = LOCKW;
         LOCKW:   if (locked)
                     state_nxt = (phase_q == PH_BASE8) ? FIN : PH_WR;
                  else if (tmr == '0)
                     state_nxt = retry_avail ? WR : FIN;
         PH_WR:   if (wr_fire && wr_idx == 4'd2) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Write index and gap flag are only live inside WR/PH_WR; every entry starts fresh.
   always_ff @(posedge CLK_50M) begin
      if (RESET) begin
         pos_q     <= '0;
         phase_q   <= '0;
         ph_word   <= '0;
         tmr       <= '0;
         wr_idx    <= '0;
         wr_gap    <= 1'b0;
         err       <= 1'b0;
         cur_pos   <= '0;
         cur_phase <= PH_BASE8;
      end else begin
         wr_idx <= '0;
         wr_gap <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               pos_q   <= req_pos;
               phase_q <= req_phase;
               err     <= 1'b0;
               ph_word <= ph_word_f(cur_phase, req_phase);
            end
            WR, PH_WR: begin
               tmr    <= TW'(RST_CYCLES - 1);
               wr_idx <= wr_idx;
               if (wr_gap) begin
                  wr_gap <= 1'b0;
               end else if (!mgmt_waitrequest) begin
                  wr_gap <= 1'b1;
                  wr_idx <= wr_idx + 4'd1;
               end
            end
            RST: tmr <= (tmr == '0) ? TW'(LOCK_TIMEOUT - 1) : tmr - TW'(1);
            LOCKW: begin
               if (locked)         ph_word <= ph_word_f(PH_BASE8, phase_q);
               else if (tmr != '0) tmr <= tmr - TW'(1);
               else if (!retry_avail) err <= 1'b1;
            end
            FIN: if (!err) begin
               cur_pos   <= pos_q;
               cur_phase <= phase_q;
            end
            default: ;
         endcase
      end
   end

`ifdef PLLSEQ_RETRY_EN
   logic retry_q;
   always_ff @(posedge CLK_50M) begin
      if (RESET)                                        retry_q <= 1'b0;
      else if (accept)                                  retry_q <= 1'b0;
      else if (state == LOCKW && !locked && tmr == '0)  retry_q <= 1'b1;
   end
   assign retry_avail = !retry_q;
`else
   assign retry_avail = 1'b0;
`endif

   always_comb begin
      mgmt_write     = 1'b0;
      mgmt_address   = '0;
      mgmt_writedata = '0;
      if (state == WR && !wr_gap) begin
         mgmt_write = 1'b1;
         case (wr_idx)
            4'd0:    begin mgmt_address = 6'd0; mgmt_writedata = 32'd0; end
            4'd1:    begin mgmt_address = 6'd4; mgmt_writedata = cfg_m; end
            4'd2:    begin mgmt_address = 6'd7; mgmt_writedata = cfg_k; end
            4'd3:    begin mgmt_address = 6'd3; mgmt_writedata = 32'h0001_0000; end
            4'd4:    begin mgmt_address = 6'd5; mgmt_writedata = cfg_c; end
            4'd5:    begin mgmt_address = 6'd5; mgmt_writedata = cfg_c | 32'h0004_0000; end
            4'd6:    begin mgmt_address = 6'd9; mgmt_writedata = 32'd1; end
            4'd7:    begin mgmt_address = 6'd8; mgmt_writedata = 32'd7; end
            default: begin mgmt_address = 6'd2; mgmt_writedata = 32'd0; end
         endcase
      end else if (state == PH_WR && !wr_gap) begin
         mgmt_write = 1'b1;
         case (wr_idx)
            4'd0:    begin mgmt_address = 6'd0; mgmt_writedata = 32'd0; end
            4'd1:    begin mgmt_address = 6'd6; mgmt_writedata = ph_word; end
            default: begin mgmt_address = 6'd2; mgmt_writedata = 32'd0; end
         endcase
      end
   end

   assign pll_reset = (state == RST);
   assign busy      = (state != IDLE) && (state != FIN);
   assign done      = (state == FIN);
   assign cfg_idx   = pos_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: table of requests plus reset-abort and invalid-index sequences.
module tb_pll_reconfig_seq;

   localparam int LT       = 300;
   localparam int RSTC     = 8;
   localparam int LOCK_DLY = 100;
`ifdef PLLSEQ_RETRY_EN
   localparam int TRIES = 2;
`else
   localparam int TRIES = 1;
`endif

   logic        CLK_50M = 1'b0;
   logic        RESET = 1'b1;
   logic        req = 1'b0;
   logic [3:0]  req_pos = '0;
   logic [7:0]  req_phase = '0;
   logic        phase_only = 1'b0;
   logic [3:0]  cfg_idx;
   logic [31:0] cfg_m, cfg_k, cfg_c;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        mgmt_write;
   logic        mgmt_waitrequest = 1'b0;
   logic        locked = 1'b0;
   logic        pll_reset, busy, done, err;
   logic [3:0]  cur_pos;
   logic [7:0]  cur_phase;

   pll_reconfig_seq #(.LOCK_TIMEOUT(LT)) dut (
      .CLK_50M(CLK_50M), .RESET(RESET), .req(req), .req_pos(req_pos), .req_phase(req_phase),
      .phase_only(phase_only), .cfg_idx(cfg_idx), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c),
      .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
      .mgmt_waitrequest(mgmt_waitrequest), .locked(locked), .pll_reset(pll_reset), .busy(busy),
      .done(done), .err(err), .cur_pos(cur_pos), .cur_phase(cur_phase)
   );

   always #10 CLK_50M = ~CLK_50M;

   function automatic logic [31:0] fm(input logic [3:0] i); return 32'hA000_0000 | {28'd0, i}; endfunction
   function automatic logic [31:0] fk(input logic [3:0] i); return 32'h0B00_0000 | {24'd0, i, 4'd0}; endfunction
   function automatic logic [31:0] fc(input logic [3:0] i); return 32'h0000_0C00 | {28'd0, i}; endfunction

   // parent frequency table lookup
   assign cfg_m = fm(cfg_idx);
   assign cfg_k = fk(cfg_idx);
   assign cfg_c = fc(cfg_idx);

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // bus slave / PLL model state
   logic [5:0]  wq_a[$];
   logic [31:0] wq_d[$];
   bit          stall_en = 0;
   bit          lock_ok = 1;
   bit          pending = 0;
   bit          prev_fire = 0;
   bit          prev_pr = 0;
   bit          busy_seen = 0;
   int          stall_left = 0;
   logic [5:0]  hold_a;
   logic [31:0] hold_d;
   int          cyc = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0;
   int          rst_len = 0, last_len = 0, rst_pulses = 0, lock_cnt = 0;

   always @(negedge CLK_50M) begin
      cyc++;
      if (busy) busy_seen = 1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_fire) chk("wr_gap", mgmt_write, 0);
      prev_fire = 0;
      if (pending) chk("wr_held", mgmt_write, 1);
      if (mgmt_write) begin
         if (!pending) begin
            hold_a = mgmt_address;
            hold_d = mgmt_writedata;
            stall_left = stall_en ? int'($urandom_range(5, 0)) : 0;
            pending = 1;
         end else begin
            chk("wr_stable", {mgmt_address, mgmt_writedata}, {hold_a, hold_d});
         end
         if (stall_left == 0) begin
            wq_a.push_back(mgmt_address);
            wq_d.push_back(mgmt_writedata);
            mgmt_waitrequest = 0;
            pending = 0;
            prev_fire = 1;
         end else begin
            stall_left--;
            mgmt_waitrequest = 1;
         end
      end else begin
         pending = 0;
         mgmt_waitrequest = 0;
      end
      if (pll_reset) begin
         locked = 0;
         rst_len++;
      end else begin
         if (prev_pr) begin
            rst_pulses++;
            last_len = rst_len;
            rst_len = 0;
            fall_cyc = cyc;
            lock_cnt = 0;
         end else begin
            lock_cnt++;
         end
         if (lock_ok && lock_cnt == LOCK_DLY) locked = 1;
      end
      prev_pr = pll_reset;
   end

   typedef struct {
      logic        po;
      logic [3:0]  pos;
      logic [7:0]  ph;
      logic        stall;
      logic        lk;
      int          nwr;
      int          nrst;
      logic        has_word;
      logic [31:0] word;
      logic [3:0]  epos;
      logic [7:0]  eph;
      logic        eerr;
   } vec_t;

   task automatic clear_mon();
      wq_a.delete();
      wq_d.delete();
      done_cnt = 0;
      rst_pulses = 0;
      busy_seen = 0;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      logic [5:0]  ea[$];
      logic [31:0] ed[$];
      int          reps;
      string       p;
      p = $sformatf("v%0d_", id);
      reps = v.lk ? 1 : TRIES;
      if (!v.po) begin
         for (int r = 0; r < reps; r++) begin
            ea.push_back(6'd0); ed.push_back(32'd0);
            ea.push_back(6'd4); ed.push_back(fm(v.pos));
            ea.push_back(6'd7); ed.push_back(fk(v.pos));
            ea.push_back(6'd3); ed.push_back(32'h0001_0000);
            ea.push_back(6'd5); ed.push_back(fc(v.pos));
            ea.push_back(6'd5); ed.push_back(fc(v.pos) | 32'h0004_0000);
            ea.push_back(6'd9); ed.push_back(32'd1);
            ea.push_back(6'd8); ed.push_back(32'd7);
            ea.push_back(6'd2); ed.push_back(32'd0);
         end
      end
      if (v.has_word) begin
         ea.push_back(6'd0); ed.push_back(32'd0);
         ea.push_back(6'd6); ed.push_back(v.word);
         ea.push_back(6'd2); ed.push_back(32'd0);
      end
      stall_en = v.stall;
      lock_ok  = v.lk;
      clear_mon();
      req = 1; phase_only = v.po; req_pos = v.pos; req_phase = v.ph;
      @(negedge CLK_50M); #1;
      req = 0;
      chk({p, "busy_early"}, busy, (v.nwr != 0));
      for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
         @(negedge CLK_50M); #1;
      end
      chk({p, "done_seen"}, (done_cnt != 0), 1);
      repeat (3) begin @(negedge CLK_50M); #1; end
      chk({p, "done_pulses"}, done_cnt, 1);
      chk({p, "nwr"}, wq_a.size(), ea.size());
      chk({p, "nwr_tb"}, ea.size(), v.nwr);
      for (int i = 0; i < ea.size() && i < wq_a.size(); i++)
         chk($sformatf("%swr%0d", p, i), {wq_a[i], wq_d[i]}, {ea[i], ed[i]});
      chk({p, "rst_pulses"}, rst_pulses, v.nrst);
      if (v.nrst != 0) chk({p, "rst_len"}, last_len, RSTC);
      if (!v.lk) chk({p, "lock_wait"}, done_cyc - fall_cyc, LT);
      chk({p, "err"}, err, v.eerr);
      chk({p, "cur_pos"}, cur_pos, v.epos);
      chk({p, "cur_phase"}, cur_phase, v.eph);
      chk({p, "cfg_idx"}, cfg_idx, v.pos);
      chk({p, "busy_end"}, busy, 0);
   endtask

   vec_t vt[10];
   vec_t va;

   initial begin
      vt[0] = '{1'b0, 4'd3,  8'd29,  1'b0, 1'b1, 9,         1,     1'b0, 32'h0,        4'd3,  8'd29,  1'b0};
      vt[1] = '{1'b1, 4'd3,  8'd31,  1'b0, 1'b1, 3,         0,     1'b1, 32'h0001_0002, 4'd3,  8'd31,  1'b0};
      vt[2] = '{1'b1, 4'd3,  8'd29,  1'b1, 1'b1, 3,         0,     1'b1, 32'h0021_0002, 4'd3,  8'd29,  1'b0};
      vt[3] = '{1'b1, 4'd3,  8'd26,  1'b0, 1'b1, 3,         0,     1'b1, 32'h0021_0003, 4'd3,  8'd26,  1'b0};
      vt[4] = '{1'b0, 4'd7,  8'd40,  1'b1, 1'b1, 12,        1,     1'b1, 32'h0001_000B, 4'd7,  8'd40,  1'b0};
      vt[5] = '{1'b0, 4'd10, 8'd10,  1'b1, 1'b1, 12,        1,     1'b1, 32'h0021_0013, 4'd10, 8'd10,  1'b0};
      vt[6] = '{1'b1, 4'd10, 8'd10,  1'b0, 1'b1, 0,         0,     1'b0, 32'h0,        4'd10, 8'd10,  1'b0};
      vt[7] = '{1'b0, 4'd2,  8'd50,  1'b0, 1'b0, 9 * TRIES, TRIES, 1'b0, 32'h0,        4'd10, 8'd10,  1'b1};
      vt[8] = '{1'b0, 4'd0,  8'd255, 1'b1, 1'b1, 12,        1,     1'b1, 32'h0001_00E2, 4'd0,  8'd255, 1'b0};
      vt[9] = '{1'b1, 4'd0,  8'd0,   1'b1, 1'b1, 3,         0,     1'b1, 32'h0021_00FF, 4'd0,  8'd0,   1'b0};

      repeat (3) @(negedge CLK_50M); #1;
      chk("reset_state",
          {mgmt_write, mgmt_address, mgmt_writedata, pll_reset, busy, done, err, cur_pos, cur_phase, cfg_idx},
          {1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd29, 4'd0});
      RESET = 0;
      @(negedge CLK_50M); #1;

      for (int i = 0; i < 10; i++) run_vec(vt[i], i);

      // abort with RESET while pll_reset is high
      stall_en = 0;
      lock_ok = 1;
      clear_mon();
      req = 1; phase_only = 0; req_pos = 4'd6; req_phase = 8'd29;
      @(negedge CLK_50M); #1;
      req = 0;
      for (int n = 0; n < 200 && !pll_reset; n++) begin @(negedge CLK_50M); #1; end
      chk("abort_rst_seen", pll_reset, 1);
      repeat (3) begin @(negedge CLK_50M); #1; end
      RESET = 1;
      @(negedge CLK_50M); #1;
      chk("abort_state",
          {mgmt_write, mgmt_address, mgmt_writedata, pll_reset, busy, done, err, cur_pos, cur_phase, cfg_idx},
          {1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd29, 4'd0});
      RESET = 0;
      repeat (2) begin @(negedge CLK_50M); #1; end
      va = '{1'b0, 4'd5, 8'd29, 1'b1, 1'b1, 9, 1, 1'b0, 32'h0, 4'd5, 8'd29, 1'b0};
      run_vec(va, 10);

      // out-of-range index must be ignored
      clear_mon();
      req = 1; phase_only = 0; req_pos = 4'd11; req_phase = 8'd60;
      @(negedge CLK_50M); #1;
      req = 0;
      repeat (30) begin @(negedge CLK_50M); #1; end
      chk("bad_pos_nwr", wq_a.size(), 0);
      chk("bad_pos_busy", busy_seen, 0);
      chk("bad_pos_done", done_cnt, 0);
      chk("bad_pos_cur", {cur_pos, cur_phase}, {4'd5, 8'd29});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
